// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one core memory bus between instruction fetch (IF)
// and load/store (LS). One transaction outstanding at a time, LS has priority,
// a starvation counter guarantees IF progress, and a jump flush discards the
// result of an in-flight fetch. A stuck slave is aborted after a timeout.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    // Instruction fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    // Load/store port
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        bus_err,
    // Memory bus
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    // Stall request to ctrl
    output logic        arb_stall
);

    localparam logic [3:0] StarveMax  = 4'(STARVE_MAX);
    localparam logic [7:0] TimeoutCyc = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyLs} state_e;

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    // Number of busy cycles seen so far, including the current one.
    logic [7:0]  timer_q, timer_d;
    logic        drop_q, drop_d;

    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;

    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        bus_err_q, bus_err_d;

    logic        gnt_if, gnt_ls;
    logic        done, timed_out;
    logic [31:0] result;

    // Arbitration happens only in IDLE and is masked while reset is asserted.
    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (rst_n && state_q == StIdle) begin
            gnt_if = if_req & ~flush & (~ls_req | (starve_q == StarveMax));
            gnt_ls = ls_req & ~gnt_if;
        end
    end

    // Completion of the current bus cycle: slave ack or timeout abort.
    always_comb begin
        done      = (state_q != StIdle) && (bus_ack || timer_q == TimeoutCyc);
        timed_out = done && !bus_ack;
        result    = timed_out ? 32'h0 : bus_rdata;
    end

    // Next-state logic for the FSM, bus registers and response registers.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        timer_d     = timer_q;
        drop_d      = drop_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        bus_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;

        unique case (state_q)
            StIdle: begin
                timer_d = 8'd0;
                drop_d  = 1'b0;
                if (gnt_if) begin
                    state_d     = StBusyIf;
                    starve_d    = 4'd0;
                    timer_d     = 8'd1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = 32'h0;
                    bus_be_d    = 4'hF;
                end else if (gnt_ls) begin
                    state_d     = StBusyLs;
                    timer_d     = 8'd1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = ls_we;
                    bus_addr_d  = ls_addr;
                    bus_wdata_d = ls_wdata;
                    bus_be_d    = ls_be;
                    // Saturate at the threshold so IF is guaranteed the next win.
                    if (if_req && starve_q != StarveMax) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            StBusyIf, StBusyLs: begin
                if (state_q == StBusyIf && flush) begin
                    drop_d = 1'b1;
                end
                if (done) begin
                    state_d   = StIdle;
                    timer_d   = 8'd0;
                    drop_d    = 1'b0;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (state_q == StBusyLs) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = result;
                        bus_err_d   = timed_out;
                    end else if (!(drop_q || flush)) begin
                        // A flush in the completing cycle also drops the fetch.
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = result;
                        bus_err_d   = timed_out;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            starve_q    <= 4'd0;
            timer_q     <= 8'd0;
            drop_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'h0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            timer_q     <= timer_d;
            drop_q      <= drop_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Output wiring; stall is forced low while reset is asserted.
    always_comb begin
        if_gnt    = gnt_if;
        ls_gnt    = gnt_ls;
        if_rvalid = if_rvalid_q;
        if_rdata  = if_rdata_q;
        ls_rvalid = ls_rvalid_q;
        ls_rdata  = ls_rdata_q;
        bus_err   = bus_err_q;
        bus_req   = bus_req_q;
        bus_we    = bus_we_q;
        bus_addr  = bus_addr_q;
        bus_wdata = bus_wdata_q;
        bus_be    = bus_be_q;
        arb_stall = rst_n & ls_req & ~ls_rvalid_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// transaction-level run checked against a behavioural model.
module tb_mem_bus_arbiter;

    localparam int unsigned STARVE_MAX  = 4;
    localparam int unsigned TIMEOUT_CYC = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic [3:0]  ls_be = 4'h0;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        arb_stall;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_be    (ls_be),
        .ls_gnt   (ls_gnt),
        .ls_rvalid(ls_rvalid),
        .ls_rdata (ls_rdata),
        .bus_err  (bus_err),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_be   (bus_be),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .arb_stall(arb_stall)
    );

    always #5 clk = ~clk;

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clear all inputs and pulse reset; returns at the start of an IDLE cycle.
    task automatic apply_reset();
        rst_n = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_be = 4'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h44; ls_addr = 32'h88;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt got %b want 0", if_gnt); end
        checks++; if (ls_gnt !== 1'b0) begin errors++; $display("FAIL reset_ls_gnt got %b want 0", ls_gnt); end
        checks++; if (arb_stall !== 1'b0) begin errors++; $display("FAIL reset_arb_stall got %b want 0", arb_stall); end
        checks++;
        if ({bus_req, bus_we, bus_be} !== 6'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got req=%b we=%b be=%h addr=%h wdata=%h want all 0",
                     bus_req, bus_we, bus_be, bus_addr, bus_wdata);
        end
        checks++;
        if ({if_rvalid, ls_rvalid, bus_err} !== 3'b0 || if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp got ifv=%b lsv=%b err=%b ifd=%h lsd=%h want all 0",
                     if_rvalid, ls_rvalid, bus_err, if_rdata, ls_rdata);
        end
        rst_n = 1'b1;
        if_req = 1'b0; ls_req = 1'b0;
        step();
    endtask

    task automatic test_if_fetch();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got if=%b ls=%b want 1/0", if_gnt, ls_gnt); end
        step();
        if_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF; end
            @(negedge clk);
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_be !== 4'hF || bus_we !== 1'b0 || if_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL fetch_bus t%0d got req=%b addr=%h be=%h we=%b rv=%b want 1/100/f/0/0",
                         i, bus_req, bus_addr, bus_be, bus_we, if_rvalid);
            end
            step();
        end
        bus_ack = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h1357_9BDF || bus_req !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rvalid got rv=%b data=%h req=%b err=%b want 1/13579bdf/0/0",
                     if_rvalid, if_rdata, bus_req, bus_err);
        end
        step();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL fetch_hold got rv=%b data=%h want 0/13579bdf", if_rvalid, if_rdata);
        end
        step();
    endtask

    task automatic test_starvation();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h400;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h3000; ls_be = 4'hF;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if (ls_gnt !== (n < 4) || if_gnt !== (n == 4)) begin
                errors++;
                $display("FAIL starve_arb%0d got if=%b ls=%b want if=%0d ls=%0d",
                         n, if_gnt, ls_gnt, n == 4, n < 4);
            end
            if (n > 0) begin
                checks++;
                if (ls_rvalid !== 1'b1) begin errors++; $display("FAIL starve_lsrv%0d got %b want 1", n, ls_rvalid); end
            end
            step();
            bus_ack = 1'b1; bus_rdata = 32'h50 + n;
            @(negedge clk);
            checks++;
            if (bus_addr !== ((n < 4) ? 32'h3000 : 32'h400)) begin
                errors++;
                $display("FAIL starve_addr%0d got %h want %h", n, bus_addr, (n < 4) ? 32'h3000 : 32'h400);
            end
            step();
            bus_ack = 1'b0;
        end
        // The IF win cleared the counter, so LS wins again despite IF waiting.
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h54 || ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL starve_after got ifrv=%b ifd=%h lsgnt=%b ifgnt=%b want 1/54/1/0",
                     if_rvalid, if_rdata, ls_gnt, if_gnt);
        end
        step();
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    task automatic test_store();
        apply_reset();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000; ls_be = 4'b0011; ls_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (ls_gnt !== 1'b1 || arb_stall !== 1'b1) begin errors++; $display("FAIL store_gnt got gnt=%b stall=%b want 1/1", ls_gnt, arb_stall); end
        step();
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== 4'b0011 || bus_addr !== 32'h2000 ||
            bus_wdata !== 32'hDEAD_BEEF || arb_stall !== 1'b1 || ls_gnt !== 1'b0) begin
            errors++;
            $display("FAIL store_bus got req=%b we=%b be=%b addr=%h wd=%h stall=%b gnt=%b",
                     bus_req, bus_we, bus_be, bus_addr, bus_wdata, arb_stall, ls_gnt);
        end
        step();
        bus_ack = 1'b1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || arb_stall !== 1'b1) begin errors++; $display("FAIL store_ack got req=%b stall=%b want 1/1", bus_req, arb_stall); end
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (ls_rvalid !== 1'b1 || arb_stall !== 1'b0 || bus_req !== 1'b0 || ls_gnt !== 1'b1) begin
            errors++;
            $display("FAIL store_done got rv=%b stall=%b req=%b gnt=%b want 1/0/0/1",
                     ls_rvalid, arb_stall, bus_req, ls_gnt);
        end
        step();
        ls_req = 1'b0;
    endtask

    task automatic test_flush();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h500; flush = 1'b1;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL flush_idle_block got %b want 0", if_gnt); end
        step();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_gnt got %b want 1", if_gnt); end
        step();
        if_req = 1'b0; flush = 1'b1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL flush_busy_req got %b want 1", bus_req); end
        step();
        flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        step();
        bus_ack = 1'b0; if_req = 1'b1; if_addr = 32'h600;
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || bus_req !== 1'b0 || if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_dropped got rv=%b data=%h req=%b gnt=%b want 0/0/0/1",
                     if_rvalid, if_rdata, bus_req, if_gnt);
        end
        step();
        if_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h600) begin errors++; $display("FAIL flush_next_bus got req=%b addr=%h want 1/600", bus_req, bus_addr); end
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL flush_next_rv got rv=%b data=%h want 1/12345678", if_rvalid, if_rdata);
        end
        step();
    endtask

    task automatic test_timeout();
        int busy = 0;
        bit got = 1'b0;
        logic       got_err = 1'b0, got_req = 1'b1;
        logic [31:0] got_data = 32'hX;
        apply_reset();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; ls_be = 4'hF;
        step();
        ls_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
        step();
        bus_ack = 1'b0; ls_req = 1'b1; ls_addr = 32'h44;
        @(negedge clk);
        checks++;
        if (ls_rdata !== 32'hA5A5_A5A5 || ls_gnt !== 1'b1) begin
            errors++;
            $display("FAIL timeout_setup got data=%h gnt=%b want a5a5a5a5/1", ls_rdata, ls_gnt);
        end
        step();
        ls_req = 1'b0; bus_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (ls_rvalid === 1'b1) begin
                got = 1'b1; got_err = bus_err; got_data = ls_rdata; got_req = bus_req;
            end else if (bus_req === 1'b1) begin
                busy++;
            end
            step();
        end
        checks++; if (!got) begin errors++; $display("FAIL timeout_rvalid got none in 300 cycles want 1"); end
        checks++; if (busy != int'(TIMEOUT_CYC)) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", busy, TIMEOUT_CYC); end
        checks++;
        if (got_err !== 1'b1 || got_data !== 32'h0 || got_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_resp got err=%b data=%h req=%b want 1/0/0", got_err, got_data, got_req);
        end
        bus_rdata = 32'h0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h80; ls_wdata = 32'h1; ls_be = 4'hF;
        step();
        ls_req = 1'b0;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", bus_req); end
        step();
        rst_n = 1'b0; bus_ack = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b want 0", bus_req); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (ls_rvalid !== 1'b0 || bus_req !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after%0d got rv=%b req=%b want 0/0", i, ls_rvalid, bus_req);
            end
        end
        step();
        if_req = 1'b1; if_addr = 32'h900;
        @(negedge clk);
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_idle_gnt got %b want 1", if_gnt); end
        step();
        if_req = 1'b0;
    endtask

    // Transaction-level model: who wins follows the priority rule plus a count
    // of consecutive IF losses; responses follow from the ack data and flushes.
    task automatic test_random();
        int          starve = 0;
        bit          exp_if_rv = 1'b0, exp_ls_rv = 1'b0;
        logic [31:0] exp_if_rd = 32'h0, exp_ls_rd = 32'h0;
        bit          win_if, win_ls, dropped;
        logic [31:0] e_addr, e_wdata, rd;
        logic        e_we;
        logic [3:0]  e_be;
        int          d;
        apply_reset();
        for (int it = 0; it < 60; it++) begin
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req = 1'b1; if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!ls_req && $urandom_range(0, 2) != 0) begin
                ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_addr = $urandom();
                ls_wdata = $urandom(); ls_be = 4'($urandom_range(0, 15));
            end
            flush = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            checks++;
            if (if_rvalid !== exp_if_rv || ls_rvalid !== exp_ls_rv || if_rdata !== exp_if_rd ||
                ls_rdata !== exp_ls_rd || bus_err !== 1'b0 || bus_req !== 1'b0) begin
                errors++;
                $display("FAIL rand_resp%0d got ifv=%b lsv=%b ifd=%h lsd=%h err=%b req=%b want %b/%b/%h/%h/0/0",
                         it, if_rvalid, ls_rvalid, if_rdata, ls_rdata, bus_err, bus_req,
                         exp_if_rv, exp_ls_rv, exp_if_rd, exp_ls_rd);
            end
            win_if = if_req && !flush && (!ls_req || starve == int'(STARVE_MAX));
            win_ls = ls_req && !win_if;
            checks++;
            if (if_gnt !== win_if || ls_gnt !== win_ls || arb_stall !== (ls_req && !exp_ls_rv)) begin
                errors++;
                $display("FAIL rand_arb%0d got if=%b ls=%b stall=%b want %b/%b/%b (starve %0d)",
                         it, if_gnt, ls_gnt, arb_stall, win_if, win_ls, ls_req && !exp_ls_rv, starve);
            end
            if (win_if) starve = 0;
            else if (win_ls && if_req && starve < int'(STARVE_MAX)) starve++;
            e_addr = win_if ? if_addr : ls_addr;
            e_we = win_if ? 1'b0 : ls_we;
            e_be = win_if ? 4'hF : ls_be;
            e_wdata = ls_wdata;
            step();
            flush = 1'b0; exp_if_rv = 1'b0; exp_ls_rv = 1'b0;
            if (!win_if && !win_ls) continue;
            if (win_if) if_req = 1'b0;
            else ls_req = 1'b0;
            d = $urandom_range(0, 3);
            dropped = 1'b0;
            rd = $urandom();
            for (int k = 0; k <= d; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    flush = 1'b1;
                    if (win_if) dropped = 1'b1;
                end
                if (k == d) begin bus_ack = 1'b1; bus_rdata = rd; end
                @(negedge clk);
                checks++;
                if (bus_req !== 1'b1 || bus_addr !== e_addr || bus_we !== e_we || bus_be !== e_be ||
                    (win_ls && bus_wdata !== e_wdata) || if_gnt !== 1'b0 || ls_gnt !== 1'b0 ||
                    arb_stall !== ls_req) begin
                    errors++;
                    $display("FAIL rand_bus%0d.%0d got req=%b addr=%h we=%b be=%h wd=%h gnt=%b%b stall=%b want addr=%h we=%b be=%h wd=%h",
                             it, k, bus_req, bus_addr, bus_we, bus_be, bus_wdata, if_gnt, ls_gnt,
                             arb_stall, e_addr, e_we, e_be, e_wdata);
                end
                step();
                flush = 1'b0; bus_ack = 1'b0;
            end
            if (win_ls) begin
                exp_ls_rv = 1'b1; exp_ls_rd = rd;
            end else if (!dropped) begin
                exp_if_rv = 1'b1; exp_if_rd = rd;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_starvation();
        test_store();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
